// File: rtl/lane_serializer.sv
// Lane serializer: captures an N-lane vector plus mask and emits the masked lanes one beat
// at a time in ascending order. Optional out_par port under LANE_SERIALIZER_PARITY_EN.
module lane_serializer #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             iv [N],
    input  logic [N-1:0]             in_mask,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic [$clog2(N)-1:0]     out_lane,
`ifdef LANE_SERIALIZER_PARITY_EN
    output logic                     out_par,
`endif
    output logic                     out_last
);

    localparam int unsigned LW = $clog2(N);

    typedef enum logic {
        StIdle,
        StSend
    } state_e;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [LW-1:0]   r_ptr;
    logic [LW-1:0]   w_ptr_nxt;
    logic [N-1:0]    r_mask;
    logic [W-1:0]    r_buf [N];

    logic [LW-1:0]   w_first;
    logic [LW-1:0]   w_next;
    logic            w_last;
    logic            w_send;
    logic            w_pop;
    logic            w_accept;

    // Lowest set bit of the incoming mask, and next set bit above ptr in the buffered mask.
    always_comb begin
        w_first = '0;
        w_next  = r_ptr;
        w_last  = 1'b1;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (in_mask[i]) begin
                w_first = LW'(i);
            end
            if (r_mask[i] && (LW'(i) > r_ptr)) begin
                w_next = LW'(i);
                w_last = 1'b0;
            end
        end
    end

    assign w_send   = (r_state == StSend);
    assign w_pop    = w_send && out_ready;
    assign in_ready = !w_send || (out_ready && w_last);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        if (w_accept) begin
            // Covers both the idle case and back-to-back acceptance on the last beat.
            if (in_mask == '0) begin
                w_state_nxt = StIdle;
            end else begin
                w_state_nxt = StSend;
                w_ptr_nxt   = w_first;
            end
        end else if (w_pop) begin
            if (w_last) begin
                w_state_nxt = StIdle;
            end else begin
                w_ptr_nxt = w_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_ptr   <= '0;
            r_mask  <= '0;
            for (int i = 0; i < int'(N); i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            if (w_accept) begin
                r_mask <= in_mask;
                r_buf  <= iv;
            end
        end
    end

    assign out_valid = w_send;
    assign out_data  = w_send ? r_buf[r_ptr] : '0;
    assign out_lane  = r_ptr;
    assign out_last  = w_send && w_last;

`ifdef LANE_SERIALIZER_PARITY_EN
    assign out_par = ^out_data;
`endif

endmodule

// File: doc/lane_serializer.md
LANE_SERIALIZER -- requirements
Module: lane_serializer

Interface
REQ-001 Parameter N, default 4: number of lanes per vector; legal range N >= 2.
REQ-002 Parameter W, default 64: lane data width in bits.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream offers a lane vector.
REQ-006 in_ready  output  1  block accepts the vector this cycle.
REQ-007 iv  input  W x [N-1:0] unpacked array  lane data, element i is lane i.
REQ-008 in_mask  input  N  bit i set means lane i shall be transmitted.
REQ-009 out_valid  output  1  output beat present.
REQ-010 out_ready  input  1  downstream accepts the beat.
REQ-011 out_data  output  W  data of the current lane.
REQ-012 out_lane  output  $clog2(N)  index of the current lane.
REQ-013 out_last  output  1  current beat is the final beat of the vector.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and SEND.
REQ-015 Acceptance SHALL occur when in_valid && in_ready; on acceptance iv and in_mask SHALL be captured into internal buffers.
REQ-016 in_ready SHALL be 1 in IDLE, and 1 in SEND only in the cycle where out_valid && out_ready && out_last; otherwise 0.
REQ-017 An accepted vector with in_mask == 0 SHALL be dropped: FSM in/to IDLE, no beat emitted.
REQ-018 An accepted nonzero vector SHALL move the FSM to SEND with the pointer at the lowest set mask bit; out_valid SHALL rise the cycle after acceptance.
REQ-019 In SEND: out_valid = 1; out_data = buffered lane[ptr]; out_lane = ptr; out_last = 1 iff no set mask bit above ptr remains.
REQ-020 On out_valid && out_ready: non-last beat advances ptr to the next higher set mask bit; last beat returns the FSM to IDLE, unless a vector is accepted in that same cycle (REQ-016), in which case REQ-017/REQ-018 apply with no bubble.
REQ-021 While out_valid && !out_ready, out_data, out_lane and out_last SHALL hold stable.
REQ-022 Changes on iv, in_mask or in_valid while in_ready = 0 SHALL have no effect on state or outputs.
REQ-023 Throughput SHALL be one beat per cycle with out_ready held high; a vector with popcount(mask) = k yields exactly k beats in ascending lane order.

Reset
REQ-024 While rst_n = 0: FSM = IDLE, out_valid = 0, out_last = 0, out_lane = 0, out_data = 0, buffers and mask cleared, in_ready = 1.
REQ-025 Reset assertion mid-SEND SHALL deassert out_valid immediately (asynchronously) and discard the in-flight vector.

Configuration
REQ-026 Macro LANE_SERIALIZER_PARITY_EN defined: an extra output out_par (1 bit) SHALL equal XOR-reduction of out_data, valid whenever out_valid = 1 and 0 in reset.
REQ-027 Macro LANE_SERIALIZER_PARITY_EN undefined: port out_par SHALL not exist; all other behaviour identical.

Verification (N=4, W=64)
REQ-028 mask 4'b1111, lanes 0x11/0x22/0x33/0x44, out_ready=1 -> beats lanes 0,1,2,3 on four consecutive cycles starting one cycle after acceptance; out_last only with lane 3 (0x44).
REQ-029 mask 4'b1010 -> two beats: lane 1 then lane 3, out_last on lane 3; lanes 0 and 2 never appear.
REQ-030 mask 4'b0000 with in_valid=1 -> out_valid stays 0, in_ready stays 1.
REQ-031 out_ready low 3 cycles during beat on lane 1, iv changed meanwhile -> out_data/out_lane held at original lane 1 value; sequence resumes unchanged.
REQ-032 Second vector (mask 4'b0001, lane0 0xAA) held on in_valid through first vector -> accepted in first vector's last-beat cycle; 0xAA beat on the very next cycle.
REQ-033 rst_n pulsed low during beat 2 of mask 4'b1111 -> out_valid drops without waiting for clk; next vector after release starts at its lowest set lane; with LANE_SERIALIZER_PARITY_EN, out_data 0x1 -> out_par 1, 0x3 -> out_par 0.
